// File: rtl/ip_io_hub.sv
// I/O port hub: decodes upstream port accesses onto one of CHANNELS downstream devices.
// Optional abort-on-silence timeout is built when IO_HUB_TIMEOUT_EN is defined.
module ip_io_hub #(
  parameter int                    CHANNELS       = 2,
  parameter logic [8*CHANNELS-1:0] BASE_ADDRS     = {8'h88, 8'h10},
  parameter logic [8*CHANNELS-1:0] ADDR_MASKS     = {8'hFC, 8'hFC},
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              bus_address,
  input  logic                    bus_ioreq,
  input  logic                    bus_write,
  input  logic                    bus_valid,
  input  logic [7:0]              bus_wdata,
  output logic                    bus_ready,
  output logic [7:0]              bus_rdata,
  output logic                    bus_rdata_en,
  output logic [CHANNELS-1:0]     ch_valid,
  output logic                    ch_write,
  output logic [7:0]              ch_address,
  output logic [7:0]              ch_wdata,
  input  logic [CHANNELS-1:0]     ch_ready,
  input  logic [8*CHANNELS-1:0]   ch_rdata,
  input  logic [CHANNELS-1:0]     ch_rdata_en,
  output logic                    timeout_flag
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             hit;
  logic [SEL_W-1:0] hit_idx;
  logic [SEL_W-1:0] sel;
  logic             accept;
  logic             sel_ready;
  logic             sel_rdata_en;
  logic [7:0]       sel_rdata;
  logic             capture;
  logic             abort_rd;
  logic             expired;

  // Descending scan so the lowest matching channel is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if ((bus_address & ADDR_MASKS[8*i +: 8]) == (BASE_ADDRS[8*i +: 8] & ADDR_MASKS[8*i +: 8])) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign bus_ready    = (state == IDLE);
  assign bus_rdata_en = (state == RESP);
  assign accept       = bus_valid & bus_ioreq & bus_ready;
  assign sel_ready    = ch_ready[sel];
  assign sel_rdata_en = ch_rdata_en[sel];
  assign sel_rdata    = ch_rdata[sel*8 +: 8];

`ifdef IO_HUB_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_flag;

  assign expired      = ((state == REQ) || (state == WAIT_RD)) && (to_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = to_flag;

  // REQ is only reachable from IDLE, so clearing while idle restarts the count on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= 8'd0;
      to_flag <= 1'b0;
    end else begin
      if (state == IDLE) begin
        to_cnt <= 8'd0;
      end else if ((state == REQ) || (state == WAIT_RD)) begin
        to_cnt <= to_cnt + 8'd1;
      end
      if (expired) begin
        to_flag <= 1'b1;
      end
    end
  end
`else
  assign expired      = 1'b0;
  // Constant 0: a legal TIMEOUT_CYCLES is never negative; the term only keeps the parameter referenced.
  assign timeout_flag = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_valid  = '0;
    capture   = 1'b0;
    abort_rd  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && hit) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (expired) begin
          abort_rd  = ~ch_write;
          state_nxt = ch_write ? IDLE : RESP;
        end else begin
          ch_valid[sel] = 1'b1;
          if (sel_ready) begin
            if (ch_write) begin
              state_nxt = IDLE;
            end else if (sel_rdata_en) begin
              capture   = 1'b1;
              state_nxt = RESP;
            end else begin
              state_nxt = WAIT_RD;
            end
          end
        end
      end
      WAIT_RD: begin
        if (sel_rdata_en) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (expired) begin
          abort_rd  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request fields are latched once at acceptance and stay frozen for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel        <= '0;
      ch_write   <= 1'b0;
      ch_address <= 8'd0;
      ch_wdata   <= 8'd0;
      bus_rdata  <= 8'hFF;
    end else begin
      if ((state == IDLE) && accept && hit) begin
        sel        <= hit_idx;
        ch_write   <= bus_write;
        ch_address <= bus_address;
        ch_wdata   <= bus_wdata;
      end
      if (capture) begin
        bus_rdata <= sel_rdata;
      end else if (abort_rd) begin
        bus_rdata <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_ip_io_hub.sv
// Randomized bench for ip_io_hub against a transaction-level decode/response model.
// Channel 1 mask is widened so it overlaps channel 0 and still leaves miss addresses.
module tb_ip_io_hub;

  localparam int          CH    = 2;
  localparam logic [15:0] BASES = {8'h88, 8'h10};
  localparam logic [15:0] MASKS = {8'h40, 8'hFC};
  localparam int          TO    = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    bus_address;
  logic          bus_ioreq;
  logic          bus_write;
  logic          bus_valid;
  logic [7:0]    bus_wdata;
  logic          bus_ready;
  logic [7:0]    bus_rdata;
  logic          bus_rdata_en;
  logic [CH-1:0] ch_valid;
  logic          ch_write;
  logic [7:0]    ch_address;
  logic [7:0]    ch_wdata;
  logic [CH-1:0] ch_ready;
  logic [8*CH-1:0] ch_rdata;
  logic [CH-1:0] ch_rdata_en;
  logic          timeout_flag;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] last_rd;

  ip_io_hub #(
    .CHANNELS(CH), .BASE_ADDRS(BASES), .ADDR_MASKS(MASKS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .bus_address(bus_address), .bus_ioreq(bus_ioreq), .bus_write(bus_write),
    .bus_valid(bus_valid), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en),
    .ch_valid(ch_valid), .ch_write(ch_write), .ch_address(ch_address), .ch_wdata(ch_wdata),
    .ch_ready(ch_ready), .ch_rdata(ch_rdata), .ch_rdata_en(ch_rdata_en),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  // Model: first channel whose masked bits agree with its base; -1 for a miss.
  function automatic int route(input logic [7:0] a);
    logic [15:0] b = BASES;
    logic [15:0] m = MASKS;
    for (int i = 0; i < CH; i++)
      if (((a ^ b[8*i +: 8]) & m[8*i +: 8]) == 8'h00) return i;
    return -1;
  endfunction

  task automatic quiet();
    ch_ready = '0; ch_rdata_en = '0; ch_rdata = '0;
  endtask

  // Random activity on every channel except sel; sel only gets junk data without a strobe.
  task automatic noise(input int sel);
    for (int i = 0; i < CH; i++) begin
      ch_rdata[8*i +: 8] = 8'($urandom);
      if (i != sel) begin
        ch_ready[i]    = 1'($urandom);
        ch_rdata_en[i] = 1'($urandom);
      end else begin
        ch_ready[i]    = 1'b0;
        ch_rdata_en[i] = 1'b0;
      end
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_chvalid"}, ch_valid, 0);
    chk({tag, "_ready"}, bus_ready, 1);
    chk({tag, "_rden"}, bus_rdata_en, 0);
    chk({tag, "_rdhold"}, bus_rdata, last_rd);
  endtask

  task automatic access(input logic [7:0] addr, input logic wr, input logic [7:0] wd,
                        input int rdy_dly, input int dat_dly, input logic [7:0] rd);
    int ch;
    ch = route(addr);
    @(negedge clk);
    chk("acc_ready", bus_ready, 1);
    bus_address = addr; bus_write = wr; bus_wdata = wd; bus_valid = 1'b1; bus_ioreq = 1'b1;
    @(negedge clk);
    bus_valid = 1'b0; bus_address = 8'($urandom); bus_wdata = 8'($urandom); bus_write = 1'($urandom);
    if (ch < 0) begin
      for (int k = 0; k < 3; k++) begin
        idle_chk("miss");
        noise(-1);
        @(negedge clk);
      end
      quiet();
      return;
    end
    for (int c = 0; c <= rdy_dly; c++) begin
      chk("req_valid", ch_valid, 32'(1 << ch));
      chk("req_addr", ch_address, addr);
      chk("req_wdata", ch_wdata, wd);
      chk("req_write", ch_write, wr);
      chk("req_busy", bus_ready, 0);
      chk("req_rden", bus_rdata_en, 0);
      noise(ch);
      if (c == rdy_dly) begin
        ch_ready[ch] = 1'b1;
        if (!wr && dat_dly == 0) begin
          ch_rdata_en[ch] = 1'b1; ch_rdata[8*ch +: 8] = rd;
        end
      end
      @(negedge clk);
    end
    quiet();
    if (wr) begin
      idle_chk("wr_done");
      return;
    end
    for (int d = 1; d <= dat_dly; d++) begin
      chk("wait_valid", ch_valid, 0);
      chk("wait_rden", bus_rdata_en, 0);
      noise(ch);
      if (d == dat_dly) begin
        ch_rdata_en[ch] = 1'b1; ch_rdata[8*ch +: 8] = rd;
      end
      @(negedge clk);
    end
    quiet();
    chk("resp_en", bus_rdata_en, 1);
    chk("resp_data", bus_rdata, rd);
    last_rd = rd;
    @(negedge clk);
    idle_chk("resp_done");
  endtask

  initial begin
    int pulses;
    reset = 1'b1; bus_address = '0; bus_ioreq = 1'b0; bus_write = 1'b0;
    bus_valid = 1'b0; bus_wdata = '0; quiet();
    last_rd = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus_ready, 1);
    chk("rst_rdata", bus_rdata, 8'hFF);
    chk("rst_rden", bus_rdata_en, 0);
    chk("rst_chvalid", ch_valid, 0);
    chk("rst_addr", {ch_write, ch_address, ch_wdata}, 0);
    chk("rst_flag", timeout_flag, 0);
    reset = 1'b0;

    access(8'h89, 1'b1, 8'h5A, 1, 0, 8'h00);
    access(8'h12, 1'b0, 8'h00, 0, 3, 8'hC3);
    access(8'h40, 1'b0, 8'h00, 0, 0, 8'h11);
    access(8'h10, 1'b0, 8'h00, 0, 1, 8'h3C);
    access(8'h13, 1'b0, 8'h00, 2, 0, 8'hA5);

    // ioreq low must be ignored even on a hit address
    @(negedge clk);
    bus_address = 8'h11; bus_write = 1'b1; bus_valid = 1'b1; bus_ioreq = 1'b0;
    repeat (3) begin
      @(negedge clk);
      idle_chk("noioreq");
    end
    bus_valid = 1'b0;

    for (int t = 0; t < 40; t++)
      access(8'($urandom), 1'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 8'($urandom));

    // Read to a channel that accepts but never returns data
    @(negedge clk);
    bus_address = 8'h12; bus_write = 1'b0; bus_valid = 1'b1; bus_ioreq = 1'b1;
    @(negedge clk);
    bus_valid = 1'b0; ch_ready[0] = 1'b1;
    @(negedge clk);
    quiet();
`ifdef IO_HUB_TIMEOUT_EN
    pulses = 0;
    for (int k = 0; k < TO + 4; k++) begin
      if (bus_rdata_en) begin
        pulses++;
        chk("to_data", bus_rdata, 8'hFF);
      end
      @(negedge clk);
    end
    chk("to_pulses", pulses, 1);
    chk("to_flag", timeout_flag, 1);
    last_rd = 8'hFF;
    idle_chk("to_done");
`else
    pulses = 0;
    for (int k = 0; k < 150; k++) begin
      if (bus_rdata_en || bus_ready) pulses++;
      @(negedge clk);
    end
    chk("silent_waits", pulses, 0);
    chk("silent_flag", timeout_flag, 0);
    ch_rdata_en[0] = 1'b1; ch_rdata[7:0] = 8'h77;
    @(negedge clk);
    quiet();
    chk("late_en", bus_rdata_en, 1);
    chk("late_data", bus_rdata, 8'h77);
    last_rd = 8'h77;
    @(negedge clk);
    idle_chk("late_done");
`endif

    // Reset while waiting for read data
    @(negedge clk);
    bus_address = 8'h12; bus_write = 1'b0; bus_valid = 1'b1; bus_ioreq = 1'b1;
    @(negedge clk);
    bus_valid = 1'b0; ch_ready[0] = 1'b1;
    @(negedge clk);
    quiet();
    reset = 1'b1; ch_rdata_en[0] = 1'b1; ch_rdata[7:0] = 8'hAA;
    @(negedge clk);
    chk("mid_ready", bus_ready, 1);
    chk("mid_rdata", bus_rdata, 8'hFF);
    chk("mid_rden", bus_rdata_en, 0);
    chk("mid_chvalid", ch_valid, 0);
    chk("mid_fields", {ch_write, ch_address, ch_wdata}, 0);
    chk("mid_flag", timeout_flag, 0);
    reset = 1'b0;
    last_rd = 8'hFF;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus_rdata_en) pulses++;
      @(negedge clk);
    end
    quiet();
    chk("mid_nopulse", pulses, 0);
    idle_chk("mid_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ip_io_hub.md
IP_IO_HUB -- requirements
Module: ip_io_hub

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of downstream I/O devices, legal range 1..8.
REQ-002 SHALL have parameter BASE_ADDRS, default {8'h88, 8'h10}: packed 8*CHANNELS bits; channel i base port in bits [8i+7:8i].
REQ-003 SHALL have parameter ADDR_MASKS, default {8'hFC, 8'hFC}: packed 8*CHANNELS bits; channel i decode mask.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64: cycles to wait for a channel response before abort, legal range 2..255.
REQ-005 clk  in  1  single clock (42.95454MHz domain); one clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 bus_address  in  8  upstream I/O port address.
REQ-008 bus_ioreq, bus_write, bus_valid  in  1 each  upstream request qualifiers.
REQ-009 bus_wdata  in  8  upstream write data.
REQ-010 bus_ready  out  1  upstream accept; high only in IDLE.
REQ-011 bus_rdata  out  8; bus_rdata_en  out  1  upstream read return, 1-cycle pulse.
REQ-012 ch_valid  out  CHANNELS  one-hot downstream request.
REQ-013 ch_write  out  1; ch_address  out  8; ch_wdata  out  8  shared downstream request fields.
REQ-014 ch_ready  in  CHANNELS; ch_rdata  in  8*CHANNELS; ch_rdata_en  in  CHANNELS  downstream responses.
REQ-015 timeout_flag  out  1  sticky: some access was aborted.

Function
REQ-016 Channel i SHALL hit when (bus_address & mask_i) == (base_i & mask_i); on multiple hits the lowest index SHALL win.
REQ-017 FSM states SHALL be IDLE, REQ, WAIT_RD, RESP.
REQ-018 An upstream access SHALL be accepted when bus_valid & bus_ioreq & bus_ready; accesses with bus_ioreq=0 SHALL be ignored.
REQ-019 On an accepted hit, the hub SHALL latch address, wdata, write and channel index, and enter REQ on the next cycle.
REQ-020 On an accepted miss, the hub SHALL stay in IDLE, drive no ch_valid and give no read response.
REQ-021 In REQ, ch_valid[sel] SHALL be held high with stable fields until ch_ready[sel]=1.
REQ-022 On ch_ready[sel]=1 in REQ: a write SHALL return to IDLE; a read SHALL go to WAIT_RD.
REQ-023 A ch_rdata_en[sel] arriving in the same cycle as ch_ready[sel] SHALL be captured, and the FSM SHALL go directly to RESP.
REQ-024 In WAIT_RD, on ch_rdata_en[sel]=1 the hub SHALL register ch_rdata[sel] and enter RESP.
REQ-025 In RESP, bus_rdata_en SHALL be 1 for exactly one cycle with the captured data, then the FSM SHALL return to IDLE; access-to-rdata_en latency SHALL be at least 2 cycles.
REQ-026 ch_rdata_en from non-selected channels, and outside WAIT_RD/REQ, SHALL be ignored.
REQ-027 bus_rdata SHALL hold its last value when bus_rdata_en=0.

Reset
REQ-028 While reset=1 the FSM SHALL be IDLE and outputs SHALL be: bus_ready=1, bus_rdata=8'hFF, bus_rdata_en=0, ch_valid=0, ch_write=0, ch_address=0, ch_wdata=0, timeout_flag=0, timeout counter=0.
REQ-029 Reset asserted mid-transaction SHALL abort it without any bus_rdata_en pulse.

Configuration
REQ-030 Macro IO_HUB_TIMEOUT_EN defined: the counter SHALL clear on entering REQ and count in REQ and WAIT_RD; on reaching TIMEOUT_CYCLES it SHALL drop ch_valid and set timeout_flag; a read SHALL then enter RESP with bus_rdata=8'hFF, and a write SHALL return to IDLE.
REQ-031 Macro IO_HUB_TIMEOUT_EN undefined: no counter SHALL exist, the hub SHALL wait indefinitely, and timeout_flag SHALL be tied to 0.

Verification
REQ-032 Write 0x5A to port 0x89, ch_ready[1] one cycle after ch_valid -> ch_valid=2'b10, ch_address=0x89, ch_wdata=0x5A, then IDLE with bus_ready=1, no rdata_en.
REQ-033 Read port 0x12, channel 0 returns 0xC3 three cycles after ready -> exactly one bus_rdata_en pulse with bus_rdata=0xC3.
REQ-034 Read port 0x40 (miss) -> ch_valid stays 0, bus_ready stays 1, no bus_rdata_en.
REQ-035 Overlapping masks (both channels match 0x10) -> only ch_valid[0] asserted.
REQ-036 With IO_HUB_TIMEOUT_EN, read to a silent channel -> after 64 cycles bus_rdata_en pulses with 0xFF and timeout_flag=1 until reset.
REQ-037 Assert reset during WAIT_RD -> next cycle outputs at REQ-028 values; no bus_rdata_en pulse.
